// File: rtl/dm_pkg.sv
`default_nettype none
// ============================================================================
// dm_pkg : size encodings, FSM states and lane/extend helpers for dm_sized
// Revision: 1.0
// ============================================================================
package dm_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // Low address bits beyond the access alignment are ignored here.
  function automatic logic [3:0] lane_en(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] en;
    case (size)
      SZ_BYTE: en = 4'b0001 << lane;
      SZ_HALF: en = lane[1] ? 4'b1100 : 4'b0011;
      default: en = 4'b1111;
    endcase
    return en;
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] d;
    case (size)
      SZ_BYTE: d = {4{wdata[7:0]}};
      SZ_HALF: d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] word, input logic [1:0] size,
                                         input logic [1:0] lane, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: r = {{24{sgn & b[7]}}, b};
      SZ_HALF: r = {{16{sgn & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic m;
    case (size)
      SZ_HALF: m = lane[0];
      SZ_WORD: m = |lane;
      SZ_RSVD: m = 1'b1;
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dm_sized_if.sv
`default_nettype none
// ============================================================================
// dm_sized_if : request/response bus between a CPU datapath and dm_sized
// Revision: 1.0
// ============================================================================
interface dm_sized_if #(
  parameter int ADDR_W = 10
);
  logic              req;
  logic              we;
  logic [ADDR_W+1:0] addr;
  logic [1:0]        size;
  logic              sign;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              ready;
  logic              err;
  logic              busy;

  modport master (output req, we, addr, size, sign, wdata,
                  input  rdata, ready, err, busy);
  modport slave  (input  req, we, addr, size, sign, wdata,
                  output rdata, ready, err, busy);
endinterface
`default_nettype wire

// File: rtl/dm_ram.sv
`default_nettype none
// ============================================================================
// dm_ram : DEPTH x 32 synchronous RAM, 4 byte write enables, registered read
// Revision: 1.0
// ============================================================================
module dm_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic [3:0]        we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;
endmodule
`default_nettype wire

// File: rtl/dm_sized.sv
`default_nettype none
// ============================================================================
// dm_sized : byte-addressed little-endian data memory with clear sequencer.
// Optional: define DM_MISALIGN_CHK_EN to flag misaligned/reserved accesses.
// Revision: 1.0
// ============================================================================
module dm_sized
  import dm_pkg::*;
#(
  parameter int          ADDR_W  = 10,
  parameter logic [31:0] CLR_VAL = 32'h0
) (
  input  logic       clk,
  input  logic       rst,
  dm_sized_if.slave  bus
);
  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              busy_q;
  logic              acc_q, st_q, sign_q, perr_q;
  logic [1:0]        size_q, lane_q;
  logic              ready_q, err_q;
  logic [31:0]       rdata_q;

  logic              accept, req_err;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata, ram_rdata;

  assign accept = bus.req && (state_q == ST_RUN);

`ifdef DM_MISALIGN_CHK_EN
  assign req_err = misaligned(bus.size, bus.addr[1:0]);
`else
  assign req_err = 1'b0;
`endif

  // The clear sequencer owns the RAM port until the FSM reaches RUN.
  always_comb begin
    ram_we    = 4'b0000;
    ram_addr  = bus.addr[ADDR_W+1:2];
    ram_wdata = lane_data(bus.size, bus.wdata);
    if (!rst) begin
      if (state_q == ST_CLEAR) begin
        ram_we    = 4'b1111;
        ram_addr  = cnt_q;
        ram_wdata = CLR_VAL;
      end else if (accept && bus.we && !req_err) begin
        ram_we = lane_en(bus.size, bus.addr[1:0]);
      end
    end
  end

  dm_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
      acc_q   <= 1'b0;
      st_q    <= 1'b0;
      sign_q  <= 1'b0;
      perr_q  <= 1'b0;
      size_q  <= SZ_BYTE;
      lane_q  <= 2'b00;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      acc_q   <= accept;
      st_q    <= bus.we;
      sign_q  <= bus.sign;
      perr_q  <= req_err;
      size_q  <= bus.size;
      lane_q  <= bus.addr[1:0];
      // Second stage: steer and extend the word the RAM read on the accept edge.
      ready_q <= acc_q;
      err_q   <= acc_q && perr_q;
      rdata_q <= (acc_q && !st_q && !perr_q) ? extend(ram_rdata, size_q, lane_q, sign_q) : '0;
      case (state_q)
        ST_CLEAR: begin
          cnt_q <= cnt_q + ADDR_W'(1);
          if (&cnt_q) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          state_q <= ST_RUN;
        end
      endcase
    end
  end

  assign bus.ready = ready_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;
  assign bus.busy  = busy_q;
endmodule
`default_nettype wire

// File: tb/tb_dm_sized.sv
`default_nettype none
// ============================================================================
// tb_dm_sized : vector table, directed corner sequences and random accesses
// against a byte-array model of dm_sized.
// Revision: 1.0
// ============================================================================
module tb_dm_sized;
  localparam int          ADDR_W  = 10;
  localparam int          DEPTH   = 1 << ADDR_W;
  localparam logic [31:0] CLR_VAL = 32'hC1C2C3C4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dm_sized_if #(.ADDR_W(ADDR_W)) bus ();

  dm_sized #(.ADDR_W(ADDR_W), .CLR_VAL(CLR_VAL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] mem_m [DEPTH*4];

  typedef struct {
    logic        w;
    logic [11:0] a;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [11:0] a,
                       input logic [1:0] sz, input logic sg, input logic [31:0] wd);
    bus.req   = r;
    bus.we    = w;
    bus.addr  = a;
    bus.size  = sz;
    bus.sign  = sg;
    bus.wdata = wd;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH*4; i++) mem_m[i] = CLR_VAL[8*(i%4) +: 8];
  endtask

  // Reference: byte-granular memory, aligned base, sign by top bit of the loaded width.
  task automatic model(input logic w, input logic [11:0] a, input logic [1:0] sz,
                       input logic sg, input logic [31:0] wd,
                       output logic [31:0] erd, output logic eer);
    int nb, base;
    logic bad;
    logic [31:0] v;
    nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    bad  = (sz == 2'd3) || ((int'(a) % nb) != 0);
`ifndef DM_MISALIGN_CHK_EN
    bad  = 1'b0;
`endif
    base = int'(a) & ~(nb - 1);
    erd  = 32'h0;
    eer  = bad;
    if (!bad) begin
      if (w) begin
        for (int i = 0; i < nb; i++) mem_m[base+i] = wd[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < nb; i++) v = v | (32'(mem_m[base+i]) << (8*i));
        if (sg && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
        erd = v;
      end
    end
  endtask

  task automatic access(input logic w, input logic [11:0] a, input logic [1:0] sz,
                        input logic sg, input logic [31:0] wd,
                        output logic [31:0] rd, output logic rdy, output logic er);
    drive(1'b1, w, a, sz, sg, wd);
    @(negedge clk);
    drive(1'b0, 1'b0, 12'h0, 2'b00, 1'b0, 32'h0);
    @(negedge clk);
    rd  = bus.rdata;
    rdy = bus.ready;
    er  = bus.err;
  endtask

  task automatic check_access(input string name, input logic w, input logic [11:0] a,
                              input logic [1:0] sz, input logic sg, input logic [31:0] wd);
    logic [31:0] erd, rd;
    logic eer, rdy, er;
    model(w, a, sz, sg, wd, erd, eer);
    access(w, a, sz, sg, wd, rd, rdy, er);
    chk({name, ".ready"}, {31'h0, rdy}, 32'h1);
    chk({name, ".rdata"}, rd, erd);
    chk({name, ".err"}, {31'h0, er}, {31'h0, eer});
  endtask

  // Optionally holds a store request on the bus for the whole clear to prove it is ignored.
  task automatic wait_clear(input string name, input logic poke);
    int c;
    int spurious;
    c = 0;
    spurious = 0;
    if (poke) drive(1'b1, 1'b1, 12'h010, 2'b10, 1'b0, 32'hFFFFFFFF);
    while (c < DEPTH + 100) begin
      @(negedge clk);
      c++;
      if (bus.ready) spurious++;
      if (!bus.busy) break;
    end
    drive(1'b0, 1'b0, 12'h0, 2'b00, 1'b0, 32'h0);
    chk({name, ".cycles"}, c, DEPTH);
    chk({name, ".no_ready"}, spurious, 0);
  endtask

  initial begin
    logic [31:0] rd, erd;
    logic rdy, er, eer;

    tbl[0]  = '{1'b1, 12'h008, 2'd2, 1'b0, 32'h00000067, 32'h00000000};
    tbl[1]  = '{1'b1, 12'h009, 2'd0, 1'b0, 32'h000000A5, 32'h00000000};
    tbl[2]  = '{1'b0, 12'h008, 2'd2, 1'b0, 32'h0,        32'h0000A567};
    tbl[3]  = '{1'b0, 12'h009, 2'd0, 1'b1, 32'h0,        32'hFFFFFFA5};
    tbl[4]  = '{1'b0, 12'h009, 2'd0, 1'b0, 32'h0,        32'h000000A5};
    tbl[5]  = '{1'b0, 12'h008, 2'd1, 1'b1, 32'h0,        32'hFFFFA567};
    tbl[6]  = '{1'b0, 12'h3FC, 2'd2, 1'b0, 32'h0,        CLR_VAL};
    tbl[7]  = '{1'b1, 12'h00E, 2'd1, 1'b0, 32'h1234BEEF, 32'h00000000};
    tbl[8]  = '{1'b0, 12'h00E, 2'd1, 1'b0, 32'h0,        32'h0000BEEF};
    tbl[9]  = '{1'b0, 12'h00F, 2'd0, 1'b1, 32'h0,        32'hFFFFFFBE};
    tbl[10] = '{1'b0, 12'h00C, 2'd2, 1'b0, 32'h0,        32'hBEEFC3C4};
    tbl[11] = '{1'b1, 12'h00C, 2'd0, 1'b0, 32'h00000080, 32'h00000000};
    tbl[12] = '{1'b0, 12'h00C, 2'd1, 1'b1, 32'h0,        32'hFFFFC380};
    tbl[13] = '{1'b0, 12'h00D, 2'd0, 1'b0, 32'h0,        32'h000000C3};

    drive(1'b0, 1'b0, 12'h0, 2'b00, 1'b0, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset.ready", {31'h0, bus.ready}, 32'h0);
    chk("reset.err",   {31'h0, bus.err},   32'h0);
    chk("reset.rdata", bus.rdata,          32'h0);
    chk("reset.busy",  {31'h0, bus.busy},  32'h1);
    rst = 1'b0;
    model_clear();
    wait_clear("clear0", 1'b0);

    for (int i = 0; i < 14; i++) begin
      model(tbl[i].w, tbl[i].a, tbl[i].sz, tbl[i].sg, tbl[i].wd, erd, eer);
      access(tbl[i].w, tbl[i].a, tbl[i].sz, tbl[i].sg, tbl[i].wd, rd, rdy, er);
      chk($sformatf("tbl%0d.ready", i), {31'h0, rdy}, 32'h1);
      chk($sformatf("tbl%0d.rdata", i), rd, tbl[i].exp);
      chk($sformatf("tbl%0d.err", i),   {31'h0, er},  32'h0);
    end

    // Store at edge N, load of the same word at N+1: responses on N+1 and N+2.
    model(1'b1, 12'h004, 2'd2, 1'b0, 32'h00000001, erd, eer);
    drive(1'b1, 1'b1, 12'h004, 2'd2, 1'b0, 32'h00000001);
    @(negedge clk);
    drive(1'b1, 1'b0, 12'h004, 2'd2, 1'b0, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 12'h0, 2'b00, 1'b0, 32'h0);
    chk("b2b.st_ready", {31'h0, bus.ready}, 32'h1);
    chk("b2b.st_rdata", bus.rdata, 32'h0);
    @(negedge clk);
    chk("b2b.ld_ready", {31'h0, bus.ready}, 32'h1);
    chk("b2b.ld_rdata", bus.rdata, 32'h00000001);
    @(negedge clk);
    chk("b2b.idle_ready", {31'h0, bus.ready}, 32'h0);
    chk("b2b.idle_rdata", bus.rdata, 32'h0);

    check_access("mis_st", 1'b1, 12'h006, 2'd2, 1'b0, 32'hDEADBEEF);
    check_access("mis_ld", 1'b0, 12'h004, 2'd2, 1'b0, 32'h0);
    check_access("rsvd_ld", 1'b0, 12'h008, 2'd3, 1'b0, 32'h0);
    check_access("mis_half", 1'b0, 12'h00F, 2'd1, 1'b1, 32'h0);

    for (int i = 0; i < 300; i++) begin
      check_access($sformatf("rnd%0d", i), 1'($urandom), 12'($urandom_range(0, 63)),
                   2'($urandom_range(0, 3)), 1'($urandom), $urandom);
    end

    // Reset one cycle after a load is accepted: the response must vanish.
    check_access("pre_rst_st", 1'b1, 12'h010, 2'd2, 1'b0, 32'h12345678);
    drive(1'b1, 1'b0, 12'h010, 2'd2, 1'b0, 32'h0);
    @(negedge clk);
    drive(1'b1, 1'b0, 12'h010, 2'd2, 1'b0, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    drive(1'b0, 1'b0, 12'h0, 2'b00, 1'b0, 32'h0);
    chk("rst_mid.ready", {31'h0, bus.ready}, 32'h0);
    chk("rst_mid.rdata", bus.rdata, 32'h0);
    chk("rst_mid.busy",  {31'h0, bus.busy},  32'h1);
    rst = 1'b0;
    model_clear();
    wait_clear("clear1", 1'b1);
    check_access("post_rst_ld", 1'b0, 12'h010, 2'd2, 1'b0, 32'h0);
    check_access("post_rst_ld2", 1'b0, 12'h008, 2'd2, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/dm_sized.md
# dm_sized

Parametrised successor to the 4 KiB word-only data memory: a byte-addressed, little-endian data memory for the single-cycle and pipelined CPU datapaths. It supports byte, halfword and word loads and stores, with sign or zero extension on loads, a registered read port and a `req`/`ready` handshake. After reset it runs a hardware clear sequencer, so memory contents are deterministic without a preload.

## Interface
- `ADDR_W`, 10: word-address bits; depth = 2**ADDR_W words (10 → 4 KiB).
- `CLR_VAL`, 32'h0: value written to every word by the reset clear sequencer.
- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req` in 1: access request, sampled each cycle while `busy`=0.
- `we` in 1: 1 = store, 0 = load; qualified by `req`.
- `addr` in ADDR_W+2: byte address; `addr[ADDR_W+1:2]` = word index, `addr[1:0]` = byte lane.
- `size` in 2: 00 byte, 01 halfword, 10 word, 11 reserved.
- `sign` in 1: loads only; 1 = sign-extend sub-word, 0 = zero-extend.
- `wdata` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `rdata` out 32: load result, valid when `ready`=1.
- `ready` out 1: one-cycle pulse one cycle after an accepted request (load or store).
- `err` out 1: misaligned/reserved access flag, valid with `ready`.
- `busy` out 1: high while the clear sequencer runs; requests are ignored.

## Operation
- FSM states: CLEAR, RUN. Reset enters CLEAR with the word counter at 0.
- CLEAR: writes `CLR_VAL` to word `cnt` each cycle and increments `cnt`. On the cycle `cnt`=DEPTH-1 is written, the FSM moves to RUN. `cnt` is ADDR_W bits wide; its wrap to 0 is not used.
- RUN: every cycle with `req`=1 is accepted (throughput 1 access/cycle); `ready` pulses in the following cycle.
- Store lane mapping: byte writes `wdata[7:0]` to lane `addr[1:0]`. Half writes `wdata[15:0]` to lanes {`addr[1]`,0}/{`addr[1]`,1}. Word writes all 4 lanes. Untouched lanes are preserved through per-byte write enables (no read-modify-write cycle).
- Load: the word is read synchronously. The selected byte or half is shifted to bit 0, then extended per `sign`. Word loads ignore `sign`.
- Store response: `ready`=1, `rdata`=0.
- Read-after-write to the same address in consecutive cycles returns the new data (the write commits on the edge before the read).
- Simultaneous `req`=1 with `rst`=1: reset wins. Request dropped, no write, no `ready`.

## Timing
- Reset values (cycle after `rst` high): `ready`=0, `err`=0, `rdata`=0, `busy`=1.
- Clear duration: exactly DEPTH cycles after `rst` deasserts. `busy` falls on the edge the FSM enters RUN; the first request is accepted in that cycle.
- Latency: request at edge N → `ready`/`rdata`/`err` valid after edge N+1, held for one cycle only. `rdata` returns to 0 when `ready`=0.
- Reset mid-operation: any in-flight response is discarded (`ready` stays 0). Clear restarts from word 0. Partially written contents are overwritten.
- `req` during CLEAR: ignored, no response ever generated.

## Configuration
- `DM_MISALIGN_CHK_EN` defined:
  - Misaligned accesses are half with `addr[0]`=1, or word with `addr[1:0]`≠0. Size 11 is reserved.
  - Misaligned or reserved accesses get `ready`=1 and `err`=1, with `rdata`=0 and no memory write.
- Undefined:
  - `err` is tied 0.
  - Low address bits are truncated to alignment (half ignores `addr[0]`, word ignores `addr[1:0]`).
  - Size 11 is treated as word.

## Structure
- Shared package `dm_pkg`: size encodings (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`, `SZ_RSVD`), FSM state encoding, lane-enable and extend helper functions.
- One sub-module, `dm_ram`: DEPTH×32 synchronous RAM with 4 byte write enables and a registered read. The top contains the FSM, clear counter, lane steering and extension logic.

## Test plan
- Reset, then count cycles until `busy`=0 → exactly 1024 cycles (ADDR_W=10). Word load from 0x3FC → 0x00000000.
- Word store 0x00000067 @0x008, then byte store 0xA5 @0x009, then word load @0x008 → 0x0000A567.
- Byte load @0x009 with `sign`=1 → 0xFFFFFFA5; with `sign`=0 → 0x000000A5. Half load @0x008 with `sign`=1 → 0xFFFFA567.
- Back-to-back: store 0x00000001 @0x004 at edge N, load @0x004 at N+1 → `ready` at N+2 with 0x00000001. `ready` high on both N+1 and N+2.
- With `DM_MISALIGN_CHK_EN`: word store 0xDEADBEEF @0x006 → `ready`=1, `err`=1. A subsequent word load @0x004 still returns the prior value.
- Assert `rst` one cycle after a load request → no `ready` pulse, `busy`=1. Clear restarts, and a previously stored word reads back as `CLR_VAL`.
